i2s_receiver: RTL and testbench
===============================

Name: i2s_receiver

Overview:
- Upstream capture stage for the audio processor transceiver.
- Deserialises an external ADC's Philips-format I2S stream (bit clock, word select, serial data) into stereo sample pairs in the input_clk domain.
- Buffers the pairs in a small show-ahead FIFO and presents them over a valid/ready interface to the processing/I2S-transmit path.

Parameters:
- SAMPLE_WIDTH, 24, captured bits per channel, MSB first; bits beyond this in a slot are ignored.
- SLOT_WIDTH, 32, bit clocks per channel slot (max); must be ≥ SAMPLE_WIDTH.
- FIFO_DEPTH, 4, stereo pairs buffered; power of two.

Ports:
- input_clk  in  1  system clock; sole clock.
- reset  in  1  asynchronous, active-high reset.
- i2s_receive_bclk  in  1  external I2S bit clock, asynchronous to input_clk.
- i2s_receive_ws  in  1  word select: 0 = left, 1 = right.
- i2s_receive_sd  in  1  serial data.
- sample_left  out  SAMPLE_WIDTH  FIFO head left sample, two's complement.
- sample_right  out  SAMPLE_WIDTH  FIFO head right sample.
- sample_valid  out  1  FIFO non-empty.
- sample_ready  in  1  consumer accepts head when high with sample_valid.
- locked  out  1  a WS transition has been seen since reset.
- overflow  out  1  one-cycle pulse: completed pair dropped, FIFO full.
- frame_error  out  1  one-cycle pulse: malformed slot detected.

Behaviour:
- Reset (async, active-high): all outputs 0; FIFO empty; synchronisers, shift register, bit_cnt, ws_prev and left_hold cleared; left_ok = 0.
- Reset asserted mid-word or mid-frame discards everything; capture restarts at the next WS transition.
- Synchronisation:
  - bclk, ws and sd each pass through a 2-FF synchroniser, then one history FF on bclk.
  - bclk_rise = sync_bclk & ~bclk_hist.
  - Constraint: bclk high and low phases each ≥ 2 input_clk periods.
- All capture actions below occur only on input_clk edges where bclk_rise = 1.
- WS change (sync_ws ≠ ws_prev):
  - The SD bit sampled on this rise belongs to the old slot and is ignored.
  - bit_cnt ← 0, ws_prev ← sync_ws, locked ← 1.
  - If locked was already 1 and the old slot had bit_cnt < SAMPLE_WIDTH: pulse frame_error, left_ok ← 0.
- Otherwise, when locked = 1:
  - bit_cnt < SAMPLE_WIDTH: shift ← {shift[SAMPLE_WIDTH-2:0], sync_sd}.
  - bit_cnt saturates at SLOT_WIDTH and increments on every rise.
  - Reaching SLOT_WIDTH+1 rises without a WS change pulses frame_error once per slot; bit_cnt holds, no capture.
- Word completion (bit_cnt transitions to SAMPLE_WIDTH), acting on the next input_clk cycle:
  - ws_prev = 0: left_hold ← shift, left_ok ← 1.
  - ws_prev = 1 and left_ok = 1: push {left_hold, shift}, left_ok ← 0.
  - ws_prev = 1 and left_ok = 0: the orphan right word is discarded silently.
- Before locked = 1, nothing is captured: the first partial frame after reset is always discarded.
- FIFO:
  - Show-ahead: sample_left/right always reflect the head; both are 0 when empty.
  - Pop when sample_valid & sample_ready.
  - Push while full and no pop: pair dropped, overflow pulses, contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged.
  - Push and pop in the same cycle while empty: push only (valid is 0).
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
- Latency: sample_valid asserts 4 input_clk rising edges after the raw bclk rise that carries the right word's bit SAMPLE_WIDTH-1 (2 sync + 1 capture + 1 push).

Decomposition:
- audio_pkg holds:
  - SAMPLE_WIDTH and SLOT_WIDTH defaults.
  - typedef stereo_sample_t (packed struct: left, right).
  - localparam I2S_WS_LEFT = 1'b0.
- One sub-module, sample_fifo: parameterised over stereo_sample_t and FIFO_DEPTH; show-ahead; exposes full, empty, push, pop.
- Synchronisers, the capture FSM (UNLOCKED → CAPTURE → PAD) and pair assembly stay in i2s_receiver.

Test Plan:
- Reset, then 3 frames at bclk = 4 input_clk periods (L = 24'h123456, R = 24'hABCDEF), sample_ready = 1:
  - First partial frame is discarded; locked = 1 after the first WS edge.
  - Each subsequent pair appears exactly 4 cycles after the right-word LSB with the values above.
- sample_ready = 0 for 6 frames, L/R = frame index:
  - Pairs 1–4 are buffered; pairs 5 and 6 each pulse overflow once.
  - On release, exactly 1,2,3,4 pop in order, then sample_valid = 0.
- WS toggles after only 10 bits in a left slot:
  - frame_error pulses once; the next right word is not pushed.
  - The following full frame pushes normally.
- WS held constant for 40 bclks after lock: frame_error pulses exactly once; no push.
- FIFO full with sample_ready = 1 and a pair completing in the same cycle: no overflow; count stays 4; the head advances.
- Reset asserted for 3 cycles mid right-word: all outputs 0 and FIFO empty immediately; the next complete frame after the first WS edge is received correctly.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio-path defaults and types used by the I2S capture stage and its FIFO.
package audio_pkg;

    localparam int DEF_SAMPLE_WIDTH = 24;
    localparam int DEF_SLOT_WIDTH   = 32;

    localparam logic I2S_WS_LEFT = 1'b0;

    typedef struct packed {
        logic [DEF_SAMPLE_WIDTH-1:0] left;
        logic [DEF_SAMPLE_WIDTH-1:0] right;
    } stereo_sample_t;

endpackage

// File: rtl/sample_fifo.sv
// Show-ahead FIFO for stereo pairs: dout always shows the head entry, and it reads as zero when empty.
module sample_fifo
    import audio_pkg::*;
#(
    parameter type T     = stereo_sample_t,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    T              r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == C_DEPTH);

    // When the FIFO is full, a push is still accepted if a pop frees a slot in the same cycle.
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    assign dout = empty ? T'('0) : r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S receiver: synchronises the ADC bit stream into input_clk and assembles left/right words
// into stereo pairs. The pairs are queued for the consumer behind a valid/ready interface.
module i2s_receiver
    import audio_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEF_SAMPLE_WIDTH,
    parameter int SLOT_WIDTH   = DEF_SLOT_WIDTH,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    input_clk,
    input  logic                    reset,
    input  logic                    i2s_receive_bclk,
    input  logic                    i2s_receive_ws,
    input  logic                    i2s_receive_sd,
    output logic [SAMPLE_WIDTH-1:0] sample_left,
    output logic [SAMPLE_WIDTH-1:0] sample_right,
    output logic                    sample_valid,
    input  logic                    sample_ready,
    output logic                    locked,
    output logic                    overflow,
    output logic                    frame_error,
    output logic [1:0]              dbg_state
);
    localparam int CW = $clog2(SLOT_WIDTH + 1);
    localparam logic [CW-1:0] C_SAMPLE = CW'(SAMPLE_WIDTH);
    localparam logic [CW-1:0] C_LAST   = CW'(SAMPLE_WIDTH - 1);
    localparam logic [CW-1:0] C_SLOT   = CW'(SLOT_WIDTH);

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_CAPTURE  = 2'd1;
    localparam logic [1:0] ST_PAD      = 2'd2;

    // Same layout as stereo_sample_t, but sized by this instance's SAMPLE_WIDTH.
    typedef struct packed {
        logic [SAMPLE_WIDTH-1:0] left;
        logic [SAMPLE_WIDTH-1:0] right;
    } pair_t;

    logic [1:0]              r_bclk_sync;
    logic [1:0]              r_ws_sync;
    logic [1:0]              r_sd_sync;
    logic                    r_bclk_hist;
    logic [1:0]              r_state;
    logic [CW-1:0]           r_bit_cnt;
    logic                    r_ws_prev;
    logic [SAMPLE_WIDTH-1:0] r_shift;
    logic [SAMPLE_WIDTH-1:0] r_left_hold;
    logic                    r_left_ok;
    logic                    r_word_done;
    logic                    r_frame_error;
    logic                    r_overflow;

    logic  w_bclk_rise;
    logic  w_ws;
    logic  w_sd;
    logic  w_push;
    logic  w_pop;
    logic  w_full;
    logic  w_empty;
    pair_t w_push_data;
    pair_t w_head;

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_bclk_sync <= '0;
            r_ws_sync   <= '0;
            r_sd_sync   <= '0;
            r_bclk_hist <= 1'b0;
        end else begin
            r_bclk_sync <= {r_bclk_sync[0], i2s_receive_bclk};
            r_ws_sync   <= {r_ws_sync[0], i2s_receive_ws};
            r_sd_sync   <= {r_sd_sync[0], i2s_receive_sd};
            r_bclk_hist <= r_bclk_sync[1];
        end
    end

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_hist;
    assign w_ws        = r_ws_sync[1];
    assign w_sd        = r_sd_sync[1];

    // A WS edge retires the old slot: the bit sampled on that rise still belongs to the old slot.
    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_UNLOCKED;
            r_bit_cnt     <= '0;
            r_ws_prev     <= I2S_WS_LEFT;
            r_shift       <= '0;
            r_left_hold   <= '0;
            r_left_ok     <= 1'b0;
            r_word_done   <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_word_done   <= 1'b0;
            r_frame_error <= 1'b0;
            if (r_word_done) begin
                if (r_ws_prev == I2S_WS_LEFT) begin
                    r_left_hold <= r_shift;
                    r_left_ok   <= 1'b1;
                end else begin
                    r_left_ok   <= 1'b0;
                end
            end
            if (w_bclk_rise) begin
                if (w_ws != r_ws_prev) begin
                    r_bit_cnt <= '0;
                    r_ws_prev <= w_ws;
                    r_state   <= ST_CAPTURE;
                    if (r_state != ST_UNLOCKED && r_bit_cnt < C_SAMPLE) begin
                        r_frame_error <= 1'b1;
                        r_left_ok     <= 1'b0;
                    end
                end else if (r_state == ST_CAPTURE) begin
                    if (r_bit_cnt < C_SAMPLE) begin
                        r_shift <= {r_shift[SAMPLE_WIDTH-2:0], w_sd};
                    end
                    if (r_bit_cnt == C_LAST) begin
                        r_word_done <= 1'b1;
                    end
                    if (r_bit_cnt == C_SLOT) begin
                        r_frame_error <= 1'b1;
                        r_state       <= ST_PAD;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

    // A right word completes a pair only if a valid left word is waiting.
    assign w_push      = r_word_done & (r_ws_prev != I2S_WS_LEFT) & r_left_ok;
    assign w_push_data = '{left: r_left_hold, right: r_shift};
    assign w_pop       = sample_ready & ~w_empty;

    sample_fifo #(
        .T     (pair_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (input_clk),
        .rst   (reset),
        .push  (w_push),
        .din   (w_push_data),
        .pop   (w_pop),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge input_clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_push & w_full & ~w_pop;
        end
    end

    assign sample_left  = w_head.left;
    assign sample_right = w_head.right;
    assign sample_valid = ~w_empty;
    assign locked       = (r_state != ST_UNLOCKED);
    assign overflow     = r_overflow;
    assign frame_error  = r_frame_error;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_i2s_receiver.sv
// Directed bench for i2s_receiver: drives Philips-format frames at bclk = 4 input_clk periods
// and checks the captured pairs, FIFO behaviour, error pulses and reset handling.
`timescale 1ns/1ps
module tb_i2s_receiver;
    localparam int SW = 24;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          bclk = 1'b0;
    logic          ws = 1'b0;
    logic          sd = 1'b0;
    logic          sample_ready = 1'b1;
    logic [SW-1:0] sample_left;
    logic [SW-1:0] sample_right;
    logic          sample_valid;
    logic          locked;
    logic          overflow;
    logic          frame_error;
    logic [1:0]    dbg_state;

    int n_checks  = 0;
    int n_pass    = 0;
    int cyc       = 0;
    int n_ovf     = 0;
    int n_ferr    = 0;
    int lsb_cyc   = 0;
    int valid_cyc = -1;
    int base;
    bit prev_valid = 1'b0;
    bit arm_pulse  = 1'b0;

    logic [2*SW-1:0] exp_q[$];
    logic [2*SW-1:0] got_q[$];

    i2s_receiver dut (
        .input_clk        (clk),
        .reset            (rst),
        .i2s_receive_bclk (bclk),
        .i2s_receive_ws   (ws),
        .i2s_receive_sd   (sd),
        .sample_left      (sample_left),
        .sample_right     (sample_right),
        .sample_valid     (sample_valid),
        .sample_ready     (sample_ready),
        .locked           (locked),
        .overflow         (overflow),
        .frame_error      (frame_error),
        .dbg_state        (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, away from the edge that updates the DUT.
    always @(negedge clk) begin
        if (sample_valid && !prev_valid) valid_cyc = cyc;
        prev_valid = sample_valid;
        if (sample_valid && sample_ready) got_q.push_back({sample_left, sample_right});
        if (overflow) n_ovf++;
        if (frame_error) n_ferr++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_scoreboard(input string tag);
        check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_pair%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
        got_q.delete();
        exp_q.delete();
    endtask

    // One input_clk step; also raises sample_ready for exactly the push edge of an armed pair.
    task automatic tick();
        @(posedge clk);
        #1;
        if (arm_pulse && cyc == lsb_cyc + 3) begin
            sample_ready = 1'b1;
        end else if (arm_pulse && cyc == lsb_cyc + 4) begin
            sample_ready = 1'b0;
            arm_pulse    = 1'b0;
        end
    endtask

    task automatic send_bit(input logic w, input logic b, input bit is_lsb);
        bclk = 1'b0;
        ws   = w;
        sd   = b;
        tick();
        tick();
        bclk = 1'b1;
        if (is_lsb) lsb_cyc = cyc;
        tick();
        tick();
    endtask

    // Rise 0 of a slot carries the previous slot's last bit; rises 1..SW carry data MSB first.
    task automatic send_slot(input logic w, input logic [SW-1:0] data, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            logic b;
            b = (i >= 1 && i <= SW) ? data[SW-i] : 1'b0;
            send_bit(w, b, (w == 1'b1) && (i == SW));
        end
    endtask

    task automatic send_frame(input logic [SW-1:0] l, input logic [SW-1:0] r);
        send_slot(1'b0, l, 32);
        send_slot(1'b1, r, 32);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        tick();
        check("rst_valid", 64'(sample_valid), 64'd0);
        check("rst_locked", 64'(locked), 64'd0);
        check("rst_left", 64'(sample_left), 64'd0);
        check("rst_right", 64'(sample_right), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_ferr", 64'(frame_error), 64'd0);
        rst = 1'b0;
        tick();

        // Partial first frame is discarded; lock on first WS edge
        send_slot(1'b0, 24'h123456, 32);
        check("t1_unlocked", 64'(locked), 64'd0);
        send_slot(1'b1, 24'hABCDEF, 32);
        check("t1_locked", 64'(locked), 64'd1);
        check("t1_state_capture", 64'(dbg_state), 64'd1);
        check_scoreboard("t1_orphan");
        for (int f = 0; f < 3; f++) begin
            valid_cyc = -1;
            send_frame(24'h123456, 24'hABCDEF);
            check($sformatf("t1_latency%0d", f), 64'(valid_cyc), 64'(lsb_cyc + 4));
            exp_q.push_back({24'h123456, 24'hABCDEF});
            check_scoreboard($sformatf("t1_frame%0d", f));
        end

        // Back-pressure: four pairs buffered, two dropped with overflow
        sample_ready = 1'b0;
        base = n_ovf;
        for (int k = 1; k <= 4; k++) send_frame(24'(k), 24'(k));
        check("t2_ovf_none", 64'(n_ovf - base), 64'd0);
        check("t2_valid_full", 64'(sample_valid), 64'd1);
        check("t2_head", 64'({sample_left, sample_right}), {16'd0, 24'd1, 24'd1});
        for (int k = 5; k <= 6; k++) send_frame(24'(k), 24'(k));
        check("t2_ovf_two", 64'(n_ovf - base), 64'd2);
        check("t2_head_kept", 64'({sample_left, sample_right}), {16'd0, 24'd1, 24'd1});
        sample_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int k = 1; k <= 4; k++) exp_q.push_back({24'(k), 24'(k)});
        check_scoreboard("t2_drain");
        check("t2_empty", 64'(sample_valid), 64'd0);

        // Short left slot: one frame_error, following right word dropped
        base = n_ferr;
        send_slot(1'b0, 24'hFFFFFF, 11);
        send_slot(1'b1, 24'h111111, 32);
        check("t3_ferr_once", 64'(n_ferr - base), 64'd1);
        check_scoreboard("t3_dropped");
        send_frame(24'h0F0F0F, 24'hF0F0F0);
        exp_q.push_back({24'h0F0F0F, 24'hF0F0F0});
        check_scoreboard("t3_recover");
        check("t3_ferr_still_once", 64'(n_ferr - base), 64'd1);

        // WS held for 40 bclks: one frame_error, no push
        base = n_ferr;
        send_slot(1'b0, 24'h777777, 40);
        check("t4_ferr_once", 64'(n_ferr - base), 64'd1);
        check("t4_state_pad", 64'(dbg_state), 64'd2);
        check_scoreboard("t4_no_push");

        // Full FIFO with simultaneous push and pop
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sample_ready = 1'b0;
        tick();
        send_slot(1'b1, 24'h0, 32);
        for (int k = 1; k <= 4; k++) send_frame(24'(24'h100000 + k), 24'(24'h200000 + k));
        base = n_ovf;
        arm_pulse = 1'b1;
        send_frame(24'h100005, 24'h200005);
        check("t5_no_ovf", 64'(n_ovf - base), 64'd0);
        check("t5_valid", 64'(sample_valid), 64'd1);
        check("t5_head_adv", 64'({sample_left, sample_right}), {16'd0, 24'h100002, 24'h200002});
        sample_ready = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        for (int k = 1; k <= 5; k++) exp_q.push_back({24'(24'h100000 + k), 24'(24'h200000 + k)});
        check_scoreboard("t5_drain");
        check("t5_empty", 64'(sample_valid), 64'd0);

        // Reset mid right-word
        sample_ready = 1'b0;
        send_frame(24'h222222, 24'h333333);
        check("t6_pre_valid", 64'(sample_valid), 64'd1);
        send_slot(1'b0, 24'h444444, 32);
        send_slot(1'b1, 24'h555555, 13);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(sample_valid), 64'd0);
        check("t6_rst_left", 64'(sample_left), 64'd0);
        check("t6_rst_right", 64'(sample_right), 64'd0);
        check("t6_rst_locked", 64'(locked), 64'd0);
        check("t6_rst_ovf", 64'(overflow), 64'd0);
        check("t6_rst_ferr", 64'(frame_error), 64'd0);
        tick();
        tick();
        tick();
        rst = 1'b0;
        sample_ready = 1'b1;
        send_slot(1'b1, 24'h0, 28);
        check("t6_relocked", 64'(locked), 64'd1);
        send_frame(24'h5A5A5A, 24'hA5A5A5);
        exp_q.push_back({24'h5A5A5A, 24'hA5A5A5});
        check_scoreboard("t6_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
